// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: drives datapath enables and
// mux selects, handles memory wait states, wait timeouts and an illegal-opcode trap.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_wren,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       writeback_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] ST_START   = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_TRAP    = 3'd6;

  localparam logic [3:0] CL_R      = 4'd0;
  localparam logic [3:0] CL_I      = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_JAL    = 4'd5;
  localparam logic [3:0] CL_JALR   = 4'd6;
  localparam logic [3:0] CL_LUI    = 4'd7;
  localparam logic [3:0] CL_AUIPC  = 4'd8;
  localparam logic [3:0] CL_ILL    = 4'd9;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ILL   = 2'b01;
  localparam logic [1:0] ERR_IMEM  = 2'b10;
  localparam logic [1:0] ERR_DMEM  = 2'b11;

  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        cls_reg, cls_next, cls_dec;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]        err_reg, err_next;
  logic [CNT_W-1:0]  instret_reg;
  logic              wait_expired;

  always_comb begin
    cls_dec = CL_ILL;
    case (opcode)
      7'b0110011: cls_dec = CL_R;
      7'b0010011: cls_dec = CL_I;
      7'b0000011: cls_dec = CL_LOAD;
      7'b0100011: cls_dec = CL_STORE;
      7'b1100011: cls_dec = CL_BRANCH;
      7'b1101111: cls_dec = CL_JAL;
      7'b1100111: cls_dec = CL_JALR;
      7'b0110111: cls_dec = CL_LUI;
      7'b0010111: cls_dec = CL_AUIPC;
      default:    cls_dec = CL_ILL;
    endcase
  end

  // Ready in the limit cycle is checked first, so it beats the timeout.
  assign wait_expired = TIMEOUT_EN && (wait_cnt_reg == WAIT_LIMIT);

  always_comb begin
    state_next    = state_reg;
    cls_next      = cls_reg;
    err_next      = err_reg;
    wait_cnt_next = '0;
    case (state_reg)
      ST_START: state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          err_next   = ERR_IMEM;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_DECODE: begin
        cls_next = cls_dec;
        if (cls_dec == CL_ILL) begin
          state_next = ST_TRAP;
          err_next   = ERR_ILL;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (cls_reg == CL_LOAD || cls_reg == CL_STORE) state_next = ST_MEM;
        else                                           state_next = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_next = (cls_reg == CL_STORE) ? ST_FETCH : ST_WB;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          err_next   = ERR_DMEM;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_WB:   state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_START;
      cls_reg      <= CL_ILL;
      wait_cnt_reg <= '0;
      err_reg      <= ERR_NONE;
      instret_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cls_reg      <= cls_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      if (retire) instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Moore decode of state and held class; ir_write and the store-completion
  // retire/pc_write are additionally qualified by the ready inputs.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_wren     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    writeback_src = 2'b00;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXECUTE: begin
        case (cls_reg)
          CL_R:                        begin alu_src_a = 2'b01; alu_src_b = 2'b00; alu_op = 2'b01; end
          CL_I:                        begin alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = 2'b01; end
          CL_LOAD, CL_STORE, CL_JALR:  begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
          CL_BRANCH, CL_JAL, CL_AUIPC: begin alu_src_a = 2'b00; alu_src_b = 2'b10; end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_wren = (cls_reg == CL_STORE);
        if (cls_reg == CL_STORE && dmem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        case (cls_reg)
          CL_LOAD:          begin reg_write = 1'b1; writeback_src = 2'b01; end
          CL_LUI:           begin reg_write = 1'b1; writeback_src = 2'b10; end
          CL_JAL, CL_JALR:  begin reg_write = 1'b1; writeback_src = 2'b11; pc_src = 1'b1; end
          CL_BRANCH:        pc_src = branch_taken;
          default:          reg_write = 1'b1;
        endcase
      end
      ST_TRAP: halted = 1'b1;
      default: ;
    endcase
  end

  assign instret   = instret_reg;
  assign err_code  = err_reg;
  assign state_dbg = state_reg;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the RV32I core. It replaces the fixed-timing control unit.
- Drives every datapath enable and mux select of the multi-cycle core: PC, IR, register file, ALU source muxes, writeback mux and PC mux.
- Adds ready/valid-style memory wait states, a bounded wait timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction decoder (opcode, funct3) and the datapath/memory.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting on imem_ready or dmem_ready before trapping; 0 disables the timeout.
- CNT_W, 32: width of the instret counter.
- WAIT_W, 8: width of the internal wait counter; MEM_TIMEOUT must be at most 2^WAIT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  from the instruction decoder (IR-derived).
- branch_taken  in  1  comparator result on reg_a/reg_b, valid from DECODE onward.
- imem_ready  in  1  instruction memory has data valid this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_wren  out  1  store write enable.
- ir_write  out  1  IR load enable.
- pc_write  out  1  PC update enable.
- pc_src  out  1  0 = pc+4, 1 = alu_out_reg.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = pc, 01 = reg_a.
- alu_src_b  out  2  00 = reg_b, 01 = 4, 10 = reg_imm.
- alu_op  out  2  00 = force add, 01 = funct-decoded.
- writeback_src  out  2  00 = alu_out_reg, 01 = mem_data_reg, 10 = reg_imm, 11 = pc+4.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- halted  out  1  sequencer is in TRAP.
- err_code  out  2  00 = none, 01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- Clocking and reset:
  - All state is updated on the clk rising edge.
  - While reset is low: state = START, wait_cnt = 0, instret = 0, err_code = 00.
- Output decoding:
  - Outputs are a Moore decode of state plus the registered instruction class.
  - The only exceptions are ir_write, retire, and the MEM→FETCH pc_write. These are qualified by the ready inputs in the same cycle.
  - Any output not listed for a state is 0.
- Instruction class: decoded from opcode at DECODE and held until FETCH. Legal opcodes:
  - R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011
  - JAL = 1101111, JALR = 1100111, LUI = 0110111, AUIPC = 0010111.
- States:
  - START: all outputs 0. Next state is FETCH unconditionally, so the first imem_req is issued in the second cycle after reset release.
  - FETCH:
    - imem_req = 1.
    - If imem_ready: ir_write = 1, go to DECODE.
    - Else wait_cnt increments. When wait_cnt = MEM_TIMEOUT-1 and ready is still low, go to TRAP with err_code = 10.
    - Ready in the limit cycle wins over the timeout.
  - DECODE: the datapath latches reg_a, reg_b and reg_imm. An illegal opcode goes to TRAP with err_code = 01; otherwise go to EXECUTE.
  - EXECUTE: ALU settings by class:
    - R: a = 01, b = 00, op = 01.
    - I: a = 01, b = 10, op = 01.
    - LOAD, STORE, JALR: a = 01, b = 10, op = 00.
    - BRANCH, JAL, AUIPC: a = 00, b = 10, op = 00.
    - LUI: ALU unused.
    - Next state: LOAD and STORE go to MEM; all other classes go to WB.
  - MEM:
    - dmem_req = 1; dmem_wren = 1 for STORE for the whole state.
    - On dmem_ready, LOAD goes to WB.
    - On dmem_ready, STORE goes to FETCH and asserts pc_write = 1, pc_src = 0 and retire = 1.
    - The timeout follows the same rule as FETCH, with err_code = 11.
  - WB: pc_write = 1 and retire = 1. Register writes by class:
    - R, I, AUIPC: reg_write = 1, wb = 00, pc_src = 0.
    - LOAD: reg_write = 1, wb = 01, pc_src = 0.
    - LUI: reg_write = 1, wb = 10, pc_src = 0.
    - JAL, JALR: reg_write = 1, wb = 11, pc_src = 1. The old PC is used, because the PC updates at the same edge.
    - BRANCH: reg_write = 0, pc_src = branch_taken.
    - Next state is FETCH.
  - TRAP: all enables 0, halted = 1, err_code held. The sequencer remains in TRAP until reset; all inputs are ignored.
- Wait counter: wait_cnt clears on every entry into FETCH or MEM.
- instret: increments by 1 on each retire and wraps modulo 2^CNT_W.
- Latency: instructions without a memory access take 4 cycles from FETCH entry to the next FETCH, given a zero-wait imem.
  - LOAD takes 5 cycles.
  - STORE takes 4 cycles.
  - Each wait cycle adds 1.
- Reset mid-operation: asserting reset in any state aborts immediately. No pc_write or reg_write occurs in that cycle or after it.

Test Plan:
- ADDI with imem_ready tied high → state sequence START, FETCH, DECODE, EXECUTE, WB, FETCH. In WB: reg_write = 1, wb = 00, pc_write = 1, pc_src = 0. instret goes 0→1.
- LW with dmem_ready low for 3 cycles → MEM lasts 4 cycles with dmem_req = 1 and dmem_wren = 0; WB has wb = 01. Total is 8 cycles from FETCH entry to the next FETCH.
- SW followed by BEQ, once with branch_taken = 1 and once with 0:
  - SW: dmem_wren = 1 throughout MEM, with no WB state.
  - BEQ: pc_src = 1 and 0 respectively, reg_write = 0 in both cases.
- JAL → EXECUTE drives a = 00 and b = 10. WB drives wb = 11, pc_src = 1, reg_write = 1.
- Opcode 1111111 → TRAP one cycle after DECODE with err_code = 01 and halted = 1. Toggling imem_ready for 20 cycles changes nothing; reset low returns the sequencer to START.
- MEM_TIMEOUT = 4 with imem_ready held low → TRAP entered after exactly 4 FETCH cycles, err_code = 10. Repeating with ready rising in the 4th cycle gives DECODE instead; also check that instret wraps at CNT_W = 4 after 16 retires.
